// File: rtl/conv2_window_feeder.sv
// conv2_window_feeder: buffers one CH x COLS feature map (ROWS pixels per
// column), the layer-2 kernels and biases, and streams 4-column windows to the
// conv-2 engine, one input channel per cycle, in bursts of 2*CH valid cycles.
// Optional feature macro: CONV2_WINDOW_FEEDER_ZPAD_EN adds one virtual zero
// column on each side of the map (col_base runs from -1 to COLS-3).
module conv2_window_feeder #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CH   = 9,
  parameter int GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_en,
  input  logic [3:0]            ld_ch,
  input  logic [3:0]            ld_col,
  input  logic [ROWS*8-1:0]     ld_data,
  input  logic                  wld_en,
  input  logic [4:0]            wld_idx,
  input  logic [71:0]           wld_data,
  input  logic                  bld_en,
  input  logic                  bld_idx,
  input  logic [15:0]           bld_data,
  input  logic                  start_i,
  input  logic                  hold_i,
  output logic [ROWS*4*8-1:0]   data_o,
  output logic [71:0]           weight_o,
  output logic [15:0]           bias_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DW = ROWS * 8;
  localparam int WW = ROWS * 4 * 8;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

`ifdef CONV2_WINDOW_FEEDER_ZPAD_EN
  localparam logic signed [5:0] COL_FIRST = -6'sd1;
  localparam logic signed [5:0] COL_LAST  = 6'(COLS - 3);
`else
  localparam logic signed [5:0] COL_FIRST = 6'sd0;
  localparam logic signed [5:0] COL_LAST  = 6'(COLS - 4);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

  // Feature map, kernels and biases; contents survive reset.
  logic [DW-1:0] fmap_mem [CH][COLS];
  logic [71:0]   wgt_mem  [2*CH];
  logic [15:0]   bias_mem [2];

  state_t               state_q, state_d;
  logic [3:0]           k_q, k_d;
  logic                 phase_q, phase_d;
  logic signed [5:0]    col_base_q, col_base_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [WW-1:0]        data_q, data_d;
  logic [71:0]          weight_q, weight_d;
  logic [15:0]          bias_q, bias_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DW-1:0]        col_pix [4];
  logic [WW-1:0]        win_d;
  logic [4:0]           widx_d;

  // Loader writes: only while idle, out-of-range slots dropped, strobes independent
  always_ff @(posedge clk) begin
    if (!busy_q) begin
      if (ld_en && (ld_ch < 4'(CH)) && (ld_col < 4'(COLS)))
        fmap_mem[ld_ch][ld_col] <= ld_data;
      if (wld_en && (wld_idx < 5'(2 * CH)))
        wgt_mem[wld_idx] <= wld_data;
      if (bld_en)
        bias_mem[bld_idx] <= bld_data;
    end
  end

  // One fmap column per window position; columns outside the map read as zero
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic signed [5:0] cidx;
    logic              in_rng;
    assign cidx        = col_base_d + $signed(6'(gi));
    assign in_rng      = (cidx >= 6'sd0) && (cidx < $signed(6'(COLS)));
    assign col_pix[gi] = in_rng ? fmap_mem[k_d][cidx[3:0]] : '0;
  end

  // Interleave the four columns so pixel (r, c) lands at byte r*4+c
  always_comb begin
    win_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_d[(r*4+c)*8 +: 8] = col_pix[c][r*8 +: 8];
      end
    end
  end

  // Next-state, counters and next output values (outputs track the next RUN slot)
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    phase_d    = phase_q;
    col_base_d = col_base_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_RUN;
          k_d        = 4'd0;
          phase_d    = 1'b0;
          col_base_d = COL_FIRST;
        end
      end
      ST_RUN: begin
        if (k_q == 4'(CH - 1)) begin
          k_d     = 4'd0;
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d   = (col_base_q == COL_LAST) ? ST_DONE : ST_GAP;
            gap_cnt_d = '0;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_GAP: begin
        // Counter saturates at GAP-1; hold_i then keeps us here
        if (gap_cnt_q < GW'(GAP - 1)) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end else if (!hold_i) begin
          state_d    = ST_RUN;
          k_d        = 4'd0;
          phase_d    = 1'b0;
          col_base_d = col_base_q + 6'sd2;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    widx_d   = phase_d ? (5'(CH) + 5'(k_d)) : 5'(k_d);
    valid_d  = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_GAP);
    done_d   = (state_d == ST_DONE);
    data_d   = valid_d ? win_d : data_q;
    weight_d = valid_d ? wgt_mem[widx_d] : weight_q;
    bias_d   = valid_d ? bias_mem[phase_d] : bias_q;
  end

  // Control FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      phase_q    <= 1'b0;
      col_base_q <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      weight_q   <= '0;
      bias_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      phase_q    <= phase_d;
      col_base_q <= col_base_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      weight_q   <= weight_d;
      bias_q     <= bias_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_o   = data_q;
  assign weight_o = weight_q;
  assign bias_o   = bias_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_conv2_window_feeder.sv
// Testbench for conv2_window_feeder: scoreboard of expected windows, burst and
// gap shape tracking, busy-write protection, hold and mid-pass reset.
`timescale 1ns/1ps
module tb_conv2_window_feeder;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CH   = 9;
  localparam int GAP  = 2;
  localparam int DW   = ROWS * 8;
  localparam int WW   = ROWS * 32;
`ifdef CONV2_WINDOW_FEEDER_ZPAD_EN
  localparam int NB  = (COLS - 2) / 2 + 1;
  localparam int CB0 = -1;
  localparam logic [31:0] FIRST_ROW0 = 32'h02010000;
  localparam logic [31:0] LAST_ROW0  = 32'h00090807;
`else
  localparam int NB  = (COLS - 4) / 2 + 1;
  localparam int CB0 = 0;
  localparam logic [31:0] FIRST_ROW0 = 32'h03020100;
  localparam logic [31:0] LAST_ROW0  = 32'h09080706;
`endif

  logic clk = 1'b0;
  logic rst_n, ld_en, wld_en, bld_en, bld_idx, start_i, hold_i;
  logic [3:0] ld_ch, ld_col;
  logic [DW-1:0] ld_data;
  logic [4:0] wld_idx;
  logic [71:0] wld_data;
  logic [15:0] bld_data;
  logic [WW-1:0] data_o;
  logic [71:0] weight_o;
  logic [15:0] bias_o;
  logic valid_o, busy_o, done_o;

  always #5 clk = ~clk;

  conv2_window_feeder #(.ROWS(ROWS), .COLS(COLS), .CH(CH), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_ch(ld_ch), .ld_col(ld_col), .ld_data(ld_data),
    .wld_en(wld_en), .wld_idx(wld_idx), .wld_data(wld_data),
    .bld_en(bld_en), .bld_idx(bld_idx), .bld_data(bld_data),
    .start_i(start_i), .hold_i(hold_i),
    .data_o(data_o), .weight_o(weight_o), .bias_o(bias_o),
    .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct packed {
    logic [WW-1:0] d;
    logic [71:0]   w;
    logic [15:0]   b;
  } exp_t;

  exp_t exp_q[$];
  logic [DW-1:0] m_col [CH][COLS];
  logic [71:0]   m_wgt [2*CH];
  logic [15:0]   m_bias [2];
  int checks = 0;
  int failures = 0;

  // monitor state
  bit mon_en = 0;
  bit prev_valid = 0;
  int run_len, gap_len, vcount, done_seen, cyc, first_v, last_v;
  int bursts_q[$];
  int gaps_q[$];

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [WW-1:0] win(input int cb, input int ch);
    logic [WW-1:0] w;
    logic [DW-1:0] cv;
    w = '0;
    for (int c = 0; c < 4; c++) begin
      cv = '0;
      if (cb + c >= 0 && cb + c < COLS) cv = m_col[ch][cb + c];
      for (int r = 0; r < ROWS; r++) w[(r*4+c)*8 +: 8] = cv[r*8 +: 8];
    end
    return w;
  endfunction

  task automatic push_pass();
    exp_t e;
    for (int b = 0; b < NB; b++)
      for (int ph = 0; ph < 2; ph++)
        for (int k = 0; k < CH; k++) begin
          e.d = win(CB0 + 2 * b, k);
          e.w = m_wgt[ph * CH + k];
          e.b = m_bias[ph];
          exp_q.push_back(e);
        end
  endtask

  task automatic mon_clear();
    bursts_q.delete(); gaps_q.delete();
    run_len = 0; gap_len = 0; vcount = 0; done_seen = 0; cyc = 0;
    first_v = -1; last_v = -1; prev_valid = 0;
  endtask

  // Scoreboard pop/compare and burst/gap shape tracking
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o) begin
        chk("sb_nonempty", WW'(exp_q.size() != 0), WW'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_o", data_o, e.d);
          chk("weight_o", WW'(weight_o), WW'(e.w));
          chk("bias_o", WW'(bias_o), WW'(e.b));
        end
        if (!prev_valid) begin
          if (bursts_q.size() > 0) gaps_q.push_back(gap_len);
          run_len = 0;
        end
        run_len++;
        vcount++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        gap_len = 0;
      end else begin
        if (prev_valid) bursts_q.push_back(run_len);
        gap_len++;
      end
      if (done_o) begin
        done_seen++;
        chk("done_after_last_valid", WW'({prev_valid, valid_o, busy_o}), WW'(3'b100));
      end
      prev_valid = valid_o;
      cyc++;
    end
  end

  task automatic run_pass(input bit spot, input int hold_at, input bit busy_wr);
    int t, hs, gc, exp_total, eg;
    mon_clear();
    mon_en = 1;
    push_pass();
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    chk("latency_valid", WW'(valid_o), WW'(1));
    if (spot) begin
      chk("first_row0", WW'(data_o[31:0]), WW'(FIRST_ROW0));
      chk("first_weight", WW'(weight_o), WW'({9{8'h00}}));
      chk("first_bias", WW'(bias_o), WW'(16'h0010));
    end
    t = 0; hs = 0; gc = 0;
    while (done_seen == 0 && t < 400) begin
      @(negedge clk); #1;
      t++;
      if (spot && vcount == 10) begin
        chk("cyc9_weight", WW'(weight_o), WW'({9{8'h09}}));
        chk("cyc9_bias", WW'(bias_o), WW'(16'h0020));
      end
      if (spot && vcount == (NB - 1) * 18 + 1 && valid_o)
        chk("last_row0", WW'(data_o[31:0]), WW'(LAST_ROW0));
      if (busy_wr) begin
        if (t == 5) begin
          ld_en = 1; ld_ch = 0; ld_col = 0; ld_data = '1;
          wld_en = 1; wld_idx = 0; wld_data = '1;
          bld_en = 1; bld_idx = 0; bld_data = '1;
        end else if (t == 6) begin
          ld_en = 0; wld_en = 0; bld_en = 0;
        end
      end
      if (t == 40) start_i = 1'b1;
      else if (t == 41) start_i = 1'b0;
      if (hold_at >= 0) begin
        if (hs == 0 && vcount == hold_at) begin hold_i = 1'b1; hs = 1; end
        else if (hs == 1 && !valid_o) begin hs = 2; gc = 1; end
        else if (hs == 2) begin
          gc++;
          if (gc == 10) begin hold_i = 1'b0; hs = 3; end
        end
      end
    end
    chk("pass_finished", WW'(done_seen > 0), WW'(1));
    // start_i while in DONE must be ignored
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_done", WW'({valid_o, busy_o}), WW'(0));
    mon_en = 0;
    chk("done_pulses", WW'(done_seen), WW'(1));
    chk("burst_count", WW'(bursts_q.size()), WW'(NB));
    foreach (bursts_q[i]) chk($sformatf("burst_len[%0d]", i), WW'(bursts_q[i]), WW'(18));
    chk("gap_count", WW'(gaps_q.size()), WW'(NB - 1));
    exp_total = NB * 18;
    for (int i = 0; i < NB - 1; i++) begin
      eg = (hold_at >= 0 && i == 1) ? 10 : GAP;
      exp_total += eg;
      if (i < gaps_q.size()) chk($sformatf("gap_len[%0d]", i), WW'(gaps_q[i]), WW'(eg));
    end
    chk("pass_cycles", WW'(last_v - first_v + 1), WW'(exp_total));
    chk("sb_drained", WW'(exp_q.size()), WW'(0));
    $display("pass done: bursts=%0d valid_cycles=%0d span=%0d", bursts_q.size(), vcount, last_v - first_v + 1);
    exp_q.delete();
  endtask

  initial begin
    int t;
    rst_n = 0; ld_en = 0; wld_en = 0; bld_en = 0; bld_idx = 0; start_i = 0; hold_i = 0;
    ld_ch = 0; ld_col = 0; ld_data = '0; wld_idx = 0; wld_data = '0; bld_data = '0;
    // model contents: row 0 pixel = ch*16+col, row r adds r so row order is visible
    for (int ch = 0; ch < CH; ch++)
      for (int col = 0; col < COLS; col++)
        for (int r = 0; r < ROWS; r++) m_col[ch][col][r*8 +: 8] = 8'(ch * 16 + col + r);
    for (int i = 0; i < 2 * CH; i++) m_wgt[i] = {9{8'(i)}};
    m_bias[0] = 16'h0010;
    m_bias[1] = 16'h0020;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", WW'(valid_o), WW'(0));
    chk("rst_busy", WW'(busy_o), WW'(0));
    chk("rst_done", WW'(done_o), WW'(0));
    chk("rst_data", data_o, '0);
    chk("rst_weight", WW'(weight_o), WW'(0));
    chk("rst_bias", WW'(bias_o), WW'(0));
    rst_n = 1;

    // load map, kernels and biases with overlapping strobes
    for (int i = 0; i < CH * COLS; i++) begin
      @(negedge clk); #1;
      ld_en = 1; ld_ch = 4'(i / COLS); ld_col = 4'(i % COLS); ld_data = m_col[i / COLS][i % COLS];
      wld_en = (i < 2 * CH); wld_idx = 5'(i); wld_data = (i < 2 * CH) ? m_wgt[i] : '0;
      bld_en = (i < 2); bld_idx = i[0]; bld_data = m_bias[i[0]];
    end
    // out-of-range writes that must be dropped
    @(negedge clk); #1;
    ld_en = 1; ld_ch = 1; ld_col = 12; ld_data = '1;
    wld_en = 1; wld_idx = 5'd20; wld_data = '1; bld_en = 0;
    @(negedge clk); #1;
    ld_ch = 9; ld_col = 0;
    @(negedge clk); #1;
    ld_en = 0; wld_en = 0;
    @(negedge clk); #1;

    run_pass(1'b1, -1, 1'b0);
    run_pass(1'b0, 28, 1'b1);
    run_pass(1'b1, -1, 1'b0);

    // reset mid-pass
    mon_clear();
    mon_en = 1;
    push_pass();
    start_i = 1;
    @(negedge clk); #1;
    start_i = 0;
    t = 0;
    while (vcount < 30 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("reached_cycle30", WW'(vcount), WW'(30));
    mon_en = 0;
    chk("pre_rst_no_done", WW'(done_seen), WW'(0));
    rst_n = 0;
    @(negedge clk); #1;
    chk("midrst_valid", WW'(valid_o), WW'(0));
    chk("midrst_busy", WW'(busy_o), WW'(0));
    chk("midrst_data", data_o, '0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk); #1;
      chk("midrst_no_done", WW'(done_o), WW'(0));
    end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_idle", WW'({valid_o, busy_o, done_o}), WW'(0));
    end
    run_pass(1'b1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
